pkt_flow_stat: RTL and testbench
================================

# pkt_flow_stat

Per-flow packet receiver and statistics block that sits at the far end of the packet generator's 64-bit stream output. It accepts every beat and checks start/end framing. On each completed packet it updates that flow's packet and byte counters. Software reads counters back through an addressed read port, the read-side counterpart of the generator's address/data/write-enable configuration ports.

## Interface
- FLOW_CNT, 16, number of flows; flow id width FLOW_CNT_WIDTH = 1 if FLOW_CNT==1 else clog2(FLOW_CNT)
- DWIDTH, 64, stream data width (fixed at 64; empty width 3)
- clk_i  in  1  system clock (156.25 MHz)
- rst_n_i  in  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low)
- pkt_data_i  in  64  stream data (not inspected, carried for completeness)
- pkt_valid_i  in  1  beat valid
- pkt_ready_o  out  1  beat accept
- pkt_sop_i  in  1  first beat of packet
- pkt_eop_i  in  1  last beat of packet
- pkt_empty_i  in  3  unused bytes in EOP beat
- pkt_flow_i  in  FLOW_CNT_WIDTH  flow id, sampled on SOP beat only
- rd_addr_i  in  FLOW_CNT_WIDTH  flow to read
- rd_sel_i  in  2  0=pkt_cnt, 1=byte_cnt[31:0], 2=byte_cnt[47:32] zero-extended, 3=error count (global, addr ignored)
- rd_en_i  in  1  read strobe
- rd_data_o  out  32  read data
- rd_valid_o  out  1  read data valid
- pkt_done_o  out  1  one-cycle pulse per counted packet

## Operation
- Beat accepted when pkt_valid_i && pkt_ready_o. pkt_ready_o=1 whenever out of reset; block never backpressures.
- Framing FSM, states IDLE and IN_PKT:
  - IDLE + SOP&EOP: single-beat packet; count it; stay IDLE.
  - IDLE + SOP&!EOP: latch flow, len=8; go to IN_PKT.
  - IDLE + !SOP: orphan beat; err_cnt+1; stay IDLE.
  - IN_PKT + !SOP&!EOP: len+=8.
  - IN_PKT + !SOP&EOP: len+=8-empty; count packet; go to IDLE.
  - IN_PKT + SOP: abort current packet (not counted, err_cnt+1); treat beat as new SOP per IDLE rules.
- Beat bytes = 8 on non-EOP beats; 8-pkt_empty_i on the EOP beat. A SOP&EOP beat carries 8-empty bytes.
- len is a 16-bit saturating accumulator at 0xFFFF.
- Count packet: pkt_cnt[flow] (32 b) +1 and byte_cnt[flow] (48 b) +len. Both saturate at all-ones. err_cnt is 16 b, saturating.
- Read: rd_data_o returns the selected counter value as it stood before any same-cycle update.

## Timing
- Counter update is registered and visible to a read issued 1 cycle after the EOP beat. pkt_done_o pulses in that same cycle.
- Read latency 1: rd_en_i at cycle N gives rd_valid_o=1 and rd_data_o at N+1. Back-to-back reads give one result per cycle.
- Reset values: pkt_ready_o=0 during reset, 1 from the first cycle after release; rd_valid_o=0; rd_data_o=0; pkt_done_o=0; all counters 0; FSM=IDLE; len=0.
- Reset asserted mid-packet: the partial packet is discarded with no error counted. All counters clear.
- Same-flow update and read in the same cycle: the read returns the old value, and the update is not lost.

## Configuration
- PKT_FLOW_STAT_RD_CLR_EN defined: a read with rd_sel_i=0 returns pkt_cnt and clears both pkt_cnt and byte_cnt of that flow. A read with rd_sel_i=3 returns err_cnt and clears it.
  - If an update hits the same flow in the clearing cycle, the counters become exactly that packet's increment (1, len).
  - The current value of byte_cnt is lost on clear, so software must read sel 1/2 before sel 0.
- Undefined: all reads are non-destructive. Counters clear only on reset.

## Test plan
- Single-beat packet, flow 3, empty=4 -> pkt_cnt[3]=1, byte_cnt[3]=4, one pkt_done_o pulse.
- 64-byte packets (8 beats, empty=0), 10 on flow 0 and 5 on flow 1 back-to-back -> pkt_cnt 10/5, byte_cnt 640/320, err_cnt=0.
- SOP, 2 beats, then new SOP on flow 2 completing as 3 beats with empty=2 -> aborted packet not counted, err_cnt=1, byte_cnt[2]=22. Then an orphan beat in IDLE -> err_cnt=2.
- Read of flow 0 sel 0 in the same cycle as flow 0's EOP when pkt_cnt=4 -> rd_data_o=4 at N+1; a following read returns 5.
- Force pkt_cnt to 0xFFFFFFFF and count one packet -> value stays 0xFFFFFFFF. Assert rst_n_i=0 mid-packet -> all reads return 0 and the next packet counts cleanly.
- With PKT_FLOW_STAT_RD_CLR_EN: read sel 0 on flow 1 (pkt_cnt=7) -> returns 7, then re-read returns 0. With a same-cycle 64-byte EOP on flow 1 -> re-read returns 1, byte_cnt=64.

Source files
------------

// File: rtl/pkt_flow_stat.sv
// pkt_flow_stat: SOP/EOP framing checker with per-flow packet/byte counters and a 1-cycle read port.
// Optional feature macro PKT_FLOW_STAT_RD_CLR_EN: sel 0 and sel 3 reads clear the counters they cover.
module pkt_flow_stat #(
  parameter  int FLOW_CNT       = 16,
  parameter  int DWIDTH         = 64,
  localparam int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [DWIDTH-1:0]         pkt_data_i,
  input  logic                      pkt_valid_i,
  output logic                      pkt_ready_o,
  input  logic                      pkt_sop_i,
  input  logic                      pkt_eop_i,
  input  logic [2:0]                pkt_empty_i,
  input  logic [FLOW_CNT_WIDTH-1:0] pkt_flow_i,
  input  logic [FLOW_CNT_WIDTH-1:0] rd_addr_i,
  input  logic [1:0]                rd_sel_i,
  input  logic                      rd_en_i,
  output logic [31:0]               rd_data_o,
  output logic                      rd_valid_o,
  output logic                      pkt_done_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] a);
    return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
  endfunction

  function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [15:0] b);
    logic [48:0] s;
    s = {1'b0, a} + {33'd0, b};
    return s[48] ? 48'hFFFF_FFFF_FFFF : s[47:0];
  endfunction

  state_t                          state_q, state_d;
  logic [FLOW_CNT_WIDTH-1:0]       flow_q, flow_d;
  logic [15:0]                     len_q, len_d;
  logic                            ready_q, ready_d;
  logic                            pkt_done_q, pkt_done_d;
  logic                            rd_valid_q, rd_valid_d;
  logic [31:0]                     rd_data_q, rd_data_d;
  logic [FLOW_CNT-1:0][31:0]       pkt_cnt_q, pkt_cnt_d;
  logic [FLOW_CNT-1:0][47:0]       byte_cnt_q, byte_cnt_d;
  logic [15:0]                     err_cnt_q, err_cnt_d;

  logic                            beat;
  logic [3:0]                      eop_bytes;
  logic                            cnt_en;
  logic [FLOW_CNT_WIDTH-1:0]       cnt_flow;
  logic [15:0]                     cnt_len;
  logic                            err_inc;
  logic                            cnt_flow_ok;
  logic                            rd_addr_ok;
  logic                            clr_flow;
  logic                            clr_err;
  logic                            unused_data;

  assign unused_data = ^pkt_data_i;
  assign beat        = pkt_valid_i & ready_q;
  assign eop_bytes   = 4'd8 - {1'b0, pkt_empty_i};
  assign ready_d     = 1'b1;
  assign cnt_flow_ok = (int'(cnt_flow) < FLOW_CNT);
  assign rd_addr_ok  = (int'(rd_addr_i) < FLOW_CNT);

`ifdef PKT_FLOW_STAT_RD_CLR_EN
  assign clr_flow = rd_en_i && (rd_sel_i == 2'd0) && rd_addr_ok;
  assign clr_err  = rd_en_i && (rd_sel_i == 2'd3);
`else
  assign clr_flow = 1'b0;
  assign clr_err  = 1'b0;
`endif

  // Framing FSM: a SOP always starts a new packet, aborting any packet still open.
  always_comb begin
    state_d  = state_q;
    flow_d   = flow_q;
    len_d    = len_q;
    cnt_en   = 1'b0;
    cnt_flow = flow_q;
    cnt_len  = 16'd0;
    err_inc  = 1'b0;
    if (beat) begin
      if (pkt_sop_i) begin
        err_inc = (state_q == ST_IN_PKT);
        if (pkt_eop_i) begin
          cnt_en   = 1'b1;
          cnt_flow = pkt_flow_i;
          cnt_len  = {12'd0, eop_bytes};
          len_d    = 16'd0;
          state_d  = ST_IDLE;
        end else begin
          flow_d  = pkt_flow_i;
          len_d   = 16'd8;
          state_d = ST_IN_PKT;
        end
      end else begin
        case (state_q)
          ST_IN_PKT: begin
            if (pkt_eop_i) begin
              cnt_en   = 1'b1;
              cnt_flow = flow_q;
              cnt_len  = sat_add16(len_q, eop_bytes);
              len_d    = 16'd0;
              state_d  = ST_IDLE;
            end else begin
              len_d = sat_add16(len_q, 4'd8);
            end
          end
          ST_IDLE: begin
            err_inc = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
            len_d   = 16'd0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Counter update; a clearing read is applied first so a same-cycle packet survives it.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    byte_cnt_d = byte_cnt_q;
    err_cnt_d  = clr_err ? 16'd0 : err_cnt_q;
    pkt_done_d = cnt_en;
    if (clr_flow) begin
      pkt_cnt_d[rd_addr_i]  = 32'd0;
      byte_cnt_d[rd_addr_i] = 48'd0;
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end
    if (cnt_en && cnt_flow_ok) begin
      pkt_cnt_d[cnt_flow]  = sat_inc32(pkt_cnt_d[cnt_flow]);
      byte_cnt_d[cnt_flow] = sat_add48(byte_cnt_d[cnt_flow], cnt_len);
    end else begin
      pkt_done_d = cnt_en;
    end
    if (err_inc) begin
      err_cnt_d = sat_inc16(err_cnt_d);
    end else begin
      pkt_done_d = cnt_en;
    end
  end

  // Read mux samples the pre-update counter values.
  always_comb begin
    rd_valid_d = rd_en_i;
    rd_data_d  = rd_data_q;
    if (rd_en_i) begin
      case (rd_sel_i)
        2'd0:    rd_data_d = rd_addr_ok ? pkt_cnt_q[rd_addr_i] : 32'd0;
        2'd1:    rd_data_d = rd_addr_ok ? byte_cnt_q[rd_addr_i][31:0] : 32'd0;
        2'd2:    rd_data_d = rd_addr_ok ? {16'd0, byte_cnt_q[rd_addr_i][47:32]} : 32'd0;
        2'd3:    rd_data_d = {16'd0, err_cnt_q};
        default: rd_data_d = 32'd0;
      endcase
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      flow_q     <= '0;
      len_q      <= 16'd0;
      ready_q    <= 1'b0;
      pkt_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      err_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      flow_q     <= flow_d;
      len_q      <= len_d;
      ready_q    <= ready_d;
      pkt_done_q <= pkt_done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign pkt_ready_o = ready_q;
  assign pkt_done_o  = pkt_done_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_pkt_flow_stat.sv
// tb_pkt_flow_stat: directed vectors plus hand-written framing, saturation and reset sequences.
`timescale 1ns/1ps
module tb_pkt_flow_stat;

`ifdef PKT_FLOW_STAT_RD_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clk_i       = 1'b0;
  logic        rst_n_i     = 1'b0;
  logic [63:0] pkt_data_i  = 64'd0;
  logic        pkt_valid_i = 1'b0;
  logic        pkt_ready_o;
  logic        pkt_sop_i   = 1'b0;
  logic        pkt_eop_i   = 1'b0;
  logic [2:0]  pkt_empty_i = 3'd0;
  logic [3:0]  pkt_flow_i  = 4'd0;
  logic [3:0]  rd_addr_i   = 4'd0;
  logic [1:0]  rd_sel_i    = 2'd0;
  logic        rd_en_i     = 1'b0;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        pkt_done_o;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  typedef struct {
    logic       v;
    logic       sop;
    logic       eop;
    logic [2:0] emp;
    logic [3:0] flow;
    logic       done;
  } beat_vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [1:0]  sel;
    logic [31:0] exp;
  } rd_vec_t;

  beat_vec_t bvec [8];
  rd_vec_t   rvec [11];

  pkt_flow_stat #(.FLOW_CNT(16), .DWIDTH(64)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .pkt_data_i  (pkt_data_i),
    .pkt_valid_i (pkt_valid_i),
    .pkt_ready_o (pkt_ready_o),
    .pkt_sop_i   (pkt_sop_i),
    .pkt_eop_i   (pkt_eop_i),
    .pkt_empty_i (pkt_empty_i),
    .pkt_flow_i  (pkt_flow_i),
    .rd_addr_i   (rd_addr_i),
    .rd_sel_i    (rd_sel_i),
    .rd_en_i     (rd_en_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .pkt_done_o  (pkt_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One stream cycle; any read strobe set up by the caller rides along.
  task automatic beat(input logic v, input logic s, input logic e,
                      input logic [2:0] emp, input logic [3:0] fl);
    pkt_valid_i = v;
    pkt_sop_i   = s;
    pkt_eop_i   = e;
    pkt_empty_i = emp;
    pkt_flow_i  = fl;
    pkt_data_i  = {$urandom, $urandom};
    @(posedge clk_i);
    #1;
    pkt_valid_i = 1'b0;
    pkt_sop_i   = 1'b0;
    pkt_eop_i   = 1'b0;
    rd_en_i     = 1'b0;
    if (pkt_done_o) done_cnt++;
  endtask

  task automatic send_pkt(input logic [3:0] fl, input int n, input logic [2:0] emp);
    for (int i = 0; i < n; i++) begin
      beat(1'b1, (i == 0), (i == n - 1), emp, fl);
    end
  endtask

  task automatic do_read(input string name, input logic [3:0] a, input logic [1:0] s,
                         input logic [31:0] exp);
    rd_en_i   = 1'b1;
    rd_addr_i = a;
    rd_sel_i  = s;
    @(posedge clk_i);
    #1;
    rd_en_i = 1'b0;
    chk({name, "_valid"}, 64'(rd_valid_o), 64'd1);
    chk(name, 64'(rd_data_o), 64'(exp));
  endtask

  initial begin
    // Framing vectors: {valid, sop, eop, empty, flow, expected pkt_done}
    bvec[0] = '{1'b1, 1'b1, 1'b1, 3'd4, 4'd3, 1'b1};
    bvec[1] = '{1'b0, 1'b1, 1'b1, 3'd0, 4'd3, 1'b0};
    bvec[2] = '{1'b1, 1'b1, 1'b0, 3'd0, 4'd7, 1'b0};
    bvec[3] = '{1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    bvec[4] = '{1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 1'b0};
    bvec[5] = '{1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    bvec[6] = '{1'b1, 1'b0, 1'b1, 3'd2, 4'd0, 1'b1};
    bvec[7] = '{1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    rvec[0]  = '{4'd3, 2'd1, 32'd4};
    rvec[1]  = '{4'd3, 2'd2, 32'd0};
    rvec[2]  = '{4'd3, 2'd0, 32'd1};
    rvec[3]  = '{4'd3, 2'd0, CLR_EN ? 32'd0 : 32'd1};
    rvec[4]  = '{4'd2, 2'd1, 32'd22};
    rvec[5]  = '{4'd2, 2'd0, 32'd1};
    rvec[6]  = '{4'd7, 2'd1, 32'd0};
    rvec[7]  = '{4'd7, 2'd0, 32'd0};
    rvec[8]  = '{4'd0, 2'd0, 32'd0};
    rvec[9]  = '{4'd0, 2'd3, 32'd2};
    rvec[10] = '{4'd0, 2'd3, CLR_EN ? 32'd0 : 32'd2};

    // Reset: beats and reads offered during reset must be ignored
    pkt_valid_i = 1'b1;
    pkt_sop_i   = 1'b1;
    pkt_eop_i   = 1'b1;
    pkt_flow_i  = 4'd3;
    rd_en_i     = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 64'(pkt_ready_o), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    chk("rst_rd_data", 64'(rd_data_o), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done_o), 64'd0);
    pkt_valid_i = 1'b0;
    pkt_sop_i   = 1'b0;
    pkt_eop_i   = 1'b0;
    rd_en_i     = 1'b0;
    rst_n_i     = 1'b1;
    @(posedge clk_i);
    #1;
    chk("ready_after_rst", 64'(pkt_ready_o), 64'd1);

    // Framing table: single beat, non-accepted beat, abort, orphan
    for (int i = 0; i < 8; i++) begin
      beat(bvec[i].v, bvec[i].sop, bvec[i].eop, bvec[i].emp, bvec[i].flow);
      chk($sformatf("beat%0d_done", i), 64'(pkt_done_o), 64'(bvec[i].done));
    end
    for (int i = 0; i < 11; i++) begin
      do_read($sformatf("rd%0d_f%0d_s%0d", i, rvec[i].addr, rvec[i].sel),
              rvec[i].addr, rvec[i].sel, rvec[i].exp);
    end
    @(posedge clk_i);
    #1;
    chk("rd_valid_idle", 64'(rd_valid_o), 64'd0);

    // 64-byte packets; fifth flow-0 EOP coincides with a flow-0 pkt_cnt read
    done_cnt = 0;
    for (int p = 0; p < 4; p++) send_pkt(4'd0, 8, 3'd0);
    for (int i = 0; i < 7; i++) beat(1'b1, (i == 0), 1'b0, 3'd0, 4'd0);
    rd_en_i   = 1'b1;
    rd_addr_i = 4'd0;
    rd_sel_i  = 2'd0;
    beat(1'b1, 1'b0, 1'b1, 3'd0, 4'd0);
    chk("samecyc_valid", 64'(rd_valid_o), 64'd1);
    chk("samecyc_old_val", 64'(rd_data_o), 64'd4);
    chk("samecyc_done", 64'(pkt_done_o), 64'd1);
    do_read("samecyc_new_val", 4'd0, 2'd0, CLR_EN ? 32'd1 : 32'd5);
    for (int p = 0; p < 5; p++) send_pkt(4'd0, 8, 3'd0);
    for (int p = 0; p < 5; p++) send_pkt(4'd1, 8, 3'd0);
    chk("done_pulses", 64'(done_cnt), 64'd15);
    do_read("f0_bytes_lo", 4'd0, 2'd1, CLR_EN ? 32'd320 : 32'd640);
    do_read("f0_bytes_hi", 4'd0, 2'd2, 32'd0);
    do_read("f0_pkts", 4'd0, 2'd0, CLR_EN ? 32'd5 : 32'd10);
    do_read("f1_bytes_lo", 4'd1, 2'd1, 32'd320);
    do_read("f1_pkts", 4'd1, 2'd0, 32'd5);
    do_read("err_unchanged", 4'd0, 2'd3, CLR_EN ? 32'd0 : 32'd2);

    // Length accumulator saturation: 8200 full beats exceed 0xFFFF bytes
    send_pkt(4'd4, 8200, 3'd0);
    do_read("len_sat_bytes", 4'd4, 2'd1, 32'h0000_FFFF);
    do_read("len_sat_pkts", 4'd4, 2'd0, 32'd1);

    // Packet counter saturation
    @(negedge clk_i);
    force dut.pkt_cnt_q = {16{32'hFFFF_FFFF}};
    #1;
    release dut.pkt_cnt_q;
    beat(1'b1, 1'b1, 1'b1, 3'd0, 4'd5);
    do_read("sat_f5_bytes", 4'd5, 2'd1, 32'd8);
    do_read("sat_f5_pkts", 4'd5, 2'd0, 32'hFFFF_FFFF);
    do_read("sat_f6_pkts", 4'd6, 2'd0, 32'hFFFF_FFFF);

    // Reset mid-packet: partial packet dropped silently, counters cleared
    beat(1'b1, 1'b1, 1'b0, 3'd0, 4'd9);
    beat(1'b1, 1'b0, 1'b0, 3'd0, 4'd9);
    rst_n_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("midrst_ready", 64'(pkt_ready_o), 64'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midrst_ready_back", 64'(pkt_ready_o), 64'd1);
    do_read("midrst_f5", 4'd5, 2'd0, 32'd0);
    do_read("midrst_f6", 4'd6, 2'd0, 32'd0);
    do_read("midrst_f4_bytes", 4'd4, 2'd1, 32'd0);
    do_read("midrst_f0", 4'd0, 2'd0, 32'd0);
    do_read("midrst_err", 4'd0, 2'd3, 32'd0);
    send_pkt(4'd9, 2, 3'd1);
    do_read("post_f9_bytes", 4'd9, 2'd1, 32'd15);
    do_read("post_f9_pkts", 4'd9, 2'd0, 32'd1);
    do_read("post_err", 4'd0, 2'd3, 32'd0);

`ifdef PKT_FLOW_STAT_RD_CLR_EN
    // Clear-on-read, including a clear colliding with an EOP on the same flow
    for (int p = 0; p < 7; p++) send_pkt(4'd1, 1, 3'd0);
    do_read("clr_f1_first", 4'd1, 2'd0, 32'd7);
    do_read("clr_f1_again", 4'd1, 2'd0, 32'd0);
    send_pkt(4'd1, 1, 3'd0);
    for (int i = 0; i < 7; i++) beat(1'b1, (i == 0), 1'b0, 3'd0, 4'd1);
    rd_en_i   = 1'b1;
    rd_addr_i = 4'd1;
    rd_sel_i  = 2'd0;
    beat(1'b1, 1'b0, 1'b1, 3'd0, 4'd1);
    chk("clr_samecyc_old", 64'(rd_data_o), 64'd1);
    do_read("clr_samecyc_bytes", 4'd1, 2'd1, 32'd64);
    do_read("clr_samecyc_pkts", 4'd1, 2'd0, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
